lisp_io_registers: RTL and testbench

LISP_IO_REGISTERS -- requirements
Module: lisp_io_registers

---
 rtl/lisp_io_pkg.sv | 48 ++++
 rtl/io_fifo.sv | 72 +++++++
 rtl/lisp_io_registers.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_lisp_io_registers.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisp_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lisp_io_pkg
//  Description : Shared definitions for the LISP core I/O register block:
//                register indices, STATUS bit positions, UART FSM states
//                and a helper that packs the STATUS word.
//  Revision    : 1.0 - initial release
// ============================================================================
package lisp_io_pkg;

   // Register map indices
   localparam logic [6:0] C_REG_LED     = 7'd0;
   localparam logic [6:0] C_REG_STATUS  = 7'd1;
   localparam logic [6:0] C_REG_TX_DATA = 7'd2;
   localparam logic [6:0] C_REG_RX_DATA = 7'd3;
   localparam logic [6:0] C_REG_CYCLE   = 7'd4;

   // STATUS bit positions
   localparam int C_STAT_TX_NOT_FULL  = 0;
   localparam int C_STAT_RX_NOT_EMPTY = 1;
   localparam int C_STAT_RX_OVERRUN   = 2;
   localparam int C_STAT_TX_BUSY      = 3;

   // Common state encoding for the TX and RX serial state machines
   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   function automatic logic [15:0] status_word(
      input logic tx_not_full,
      input logic rx_not_empty,
      input logic rx_overrun,
      input logic tx_busy
   );
      logic [15:0] w;
      w                      = '0;
      w[C_STAT_TX_NOT_FULL]  = tx_not_full;
      w[C_STAT_RX_NOT_EMPTY] = rx_not_empty;
      w[C_STAT_RX_OVERRUN]   = rx_overrun;
      w[C_STAT_TX_BUSY]      = tx_busy;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : io_fifo
//  Description : Small synchronous FIFO with show-ahead head output.
//                A push and a pop in the same cycle both take effect; a push
//                while full is accepted only if a pop frees the slot in the
//                same cycle, otherwise it is dropped. A pop while empty is
//                ignored. DEPTH must be a power of two, at least 2.
//  Ports       : clk_i   - clock
//                rst_i   - asynchronous active-high reset (empties FIFO)
//                push_i  - write data_i into the tail
//                data_i  - write data
//                pop_i   - discard the head entry
//                full_o  - DEPTH entries held
//                empty_o - no entries held
//                head_o  - oldest entry (valid when !empty_o)
//  Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;

   logic w_do_pop;
   logic w_do_push;

   assign full_o    = (count_q == C_DEPTH);
   assign empty_o   = (count_q == '0);
   assign head_o    = mem_q[rd_ptr_q];
   assign w_do_pop  = pop_i && !empty_o;
   assign w_do_push = push_i && (!full_o || w_do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers
   always_ff @(posedge clk_i) begin
      if (w_do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/lisp_io_registers.sv
`default_nettype none
// ============================================================================
//  Module      : lisp_io_registers
//  Description : Memory-mapped I/O register block for the LISP core: LED
//                register, STATUS, UART transmit/receive data (8N1, each
//                direction buffered by an io_fifo) and a free-running cycle
//                counter. Read data is registered one cycle after the strobe.
//  Ports       : clk                  - sole clock, rising edge
//                reset                - asynchronous active-high reset
//                register_index       - register select
//                register_read        - bus access strobe (also high on writes)
//                register_write       - write strobe
//                register_write_value - write data
//                register_read_value  - registered read data
//                uart_tx              - serial out, idle high
//                uart_rx              - serial in, asynchronous to clk
//                led                  - LED register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module lisp_io_registers
   import lisp_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  register_index,
   input  logic        register_read,
   input  logic        register_write,
   input  logic [15:0] register_write_value,
   output logic [15:0] register_read_value,
   output logic        uart_tx,
   input  logic        uart_rx,
   output logic [15:0] led
);

   localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  C_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  C_HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

   // ---------------------------------------------------------------- state
   logic [15:0] led_q, led_d;
   logic [15:0] rdata_q, rdata_d;
   logic [15:0] cycle_q, cycle_d;
   logic        rx_overrun_q, rx_overrun_d;

   logic        rx_meta_q, rx_sync_q, rx_prev_q;

   uart_state_e      tx_state_q;
   logic [CNT_W-1:0] tx_cnt_q;
   logic [2:0]       tx_bit_q;
   logic [7:0]       tx_shift_q;
   logic             tx_line_q;

   uart_state_e      rx_state_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [2:0]       rx_bit_q;
   logic [7:0]       rx_shift_q;
   logic             rx_push_q;

   // ---------------------------------------------------------------- wires
   logic        w_pure_read;
   logic        w_wr_led;
   logic        w_wr_tx;
   logic        w_rd_status;
   logic        w_rd_rx;
   logic        w_tx_full, w_tx_empty, w_tx_pop, w_tx_busy;
   logic [7:0]  w_tx_head;
   logic        w_rx_full, w_rx_empty, w_rx_pop;
   logic [7:0]  w_rx_head;
   logic        w_overrun_set;
   logic [15:0] w_read_mux;

   // Read side effects apply only when the access is not also a write
   assign w_pure_read = register_read && !register_write;
   assign w_wr_led    = register_write && (register_index == C_REG_LED);
   assign w_wr_tx     = register_write && (register_index == C_REG_TX_DATA);
   assign w_rd_status = w_pure_read && (register_index == C_REG_STATUS);
   assign w_rd_rx     = w_pure_read && (register_index == C_REG_RX_DATA);
   assign w_rx_pop    = w_rd_rx && !w_rx_empty;

   // TX takes a byte when idle, or at the end of a stop bit so that queued
   // bytes follow each other with no idle gap
   assign w_tx_pop  = !w_tx_empty &&
                      ((tx_state_q == UART_IDLE) ||
                       ((tx_state_q == UART_STOP) && (tx_cnt_q == C_BIT_LAST)));
   assign w_tx_busy = (tx_state_q != UART_IDLE);

   // A received byte that finds no room (and no slot freed by a read this
   // cycle) is lost and flagged
   assign w_overrun_set = rx_push_q && w_rx_full && !w_rx_pop;

   // ---------------------------------------------------------------- FIFOs
   io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (w_wr_tx),
      .data_i  (register_write_value[7:0]),
      .pop_i   (w_tx_pop),
      .full_o  (w_tx_full),
      .empty_o (w_tx_empty),
      .head_o  (w_tx_head)
   );

   io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (rx_push_q),
      .data_i  (rx_shift_q),
      .pop_i   (w_rx_pop),
      .full_o  (w_rx_full),
      .empty_o (w_rx_empty),
      .head_o  (w_rx_head)
   );

   // ---------------------------------------------------------------- read mux
   always_comb begin
      w_read_mux = '0;
      case (register_index)
         C_REG_LED:     w_read_mux = led_q;
         C_REG_STATUS:  w_read_mux = status_word(!w_tx_full, !w_rx_empty,
                                                 rx_overrun_q, w_tx_busy);
         C_REG_RX_DATA: w_read_mux = {8'h00, (w_rx_empty ? 8'h00 : w_rx_head)};
         C_REG_CYCLE:   w_read_mux = cycle_q;
         default:       w_read_mux = '0;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_comb begin
      led_d        = led_q;
      rdata_d      = rdata_q;
      cycle_d      = cycle_q + 16'd1;
      rx_overrun_d = rx_overrun_q;
      if (w_wr_led)      led_d        = register_write_value;
      if (register_read) rdata_d      = w_read_mux;
      if (w_rd_status)   rx_overrun_d = 1'b0;
      if (w_overrun_set) rx_overrun_d = 1'b1;   // a new overrun beats the clear
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q        <= '0;
         rdata_q      <= '0;
         cycle_q      <= '0;
         rx_overrun_q <= 1'b0;
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
      end else begin
         led_q        <= led_d;
         rdata_q      <= rdata_d;
         cycle_q      <= cycle_d;
         rx_overrun_q <= rx_overrun_d;
         rx_meta_q    <= uart_rx;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= UART_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
      end else begin
         case (tx_state_q)
            UART_IDLE: begin
               tx_cnt_q <= '0;
               if (!w_tx_empty) begin
                  tx_state_q <= UART_START;
                  tx_shift_q <= w_tx_head;
                  tx_line_q  <= 1'b0;
               end
            end
            UART_START: begin
               if (tx_cnt_q == C_BIT_LAST) begin
                  tx_state_q <= UART_DATA;
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  tx_line_q  <= tx_shift_q[0];
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            UART_DATA: begin
               if (tx_cnt_q == C_BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 3'd7) begin
                     tx_state_q <= UART_STOP;
                     tx_line_q  <= 1'b1;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 1'b1;
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     tx_line_q  <= tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            UART_STOP: begin
               if (tx_cnt_q == C_BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (!w_tx_empty) begin
                     tx_state_q <= UART_START;
                     tx_shift_q <= w_tx_head;
                     tx_line_q  <= 1'b0;
                  end else begin
                     tx_state_q <= UART_IDLE;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            default: begin
               tx_state_q <= UART_IDLE;
               tx_line_q  <= 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- RX FSM
   // Bit timing is measured from the detected falling edge; the start bit
   // is checked at its middle and every later sample is one bit further on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_q <= UART_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_push_q  <= 1'b0;
      end else begin
         rx_push_q <= 1'b0;
         case (rx_state_q)
            UART_IDLE: begin
               rx_cnt_q <= '0;
               if (rx_prev_q && !rx_sync_q) rx_state_q <= UART_START;
            end
            UART_START: begin
               if (rx_cnt_q == C_HALF_BIT) begin
                  rx_cnt_q <= '0;
                  rx_bit_q <= '0;
                  // A line already back high was a glitch, not a start bit
                  rx_state_q <= rx_sync_q ? UART_IDLE : UART_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            UART_DATA: begin
               if (rx_cnt_q == C_BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_q <= UART_STOP;
                  else                  rx_bit_q   <= rx_bit_q + 1'b1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            UART_STOP: begin
               if (rx_cnt_q == C_BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= UART_IDLE;
                  // Framing error (stop bit low) drops the byte
                  rx_push_q  <= rx_sync_q;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            default: rx_state_q <= UART_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign register_read_value = rdata_q;
   assign uart_tx             = tx_line_q;
   assign led                 = led_q;

endmodule
`default_nettype wire

// File: tb/tb_lisp_io_registers.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lisp_io_registers
//  Description : Self-checking bench for lisp_io_registers. A behavioural
//                model (LED value, RX byte queue, overrun flag) predicts all
//                register reads; a serial monitor decodes uart_tx frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lisp_io_registers;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   localparam logic [6:0] A_LED    = 7'd0;
   localparam logic [6:0] A_STATUS = 7'd1;
   localparam logic [6:0] A_TX     = 7'd2;
   localparam logic [6:0] A_RX     = 7'd3;
   localparam logic [6:0] A_CYCLE  = 7'd4;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  register_index;
   logic        register_read;
   logic        register_write;
   logic [15:0] register_write_value;
   logic [15:0] register_read_value;
   logic        uart_tx;
   logic        uart_rx;
   logic [15:0] led;

   int checks = 0;
   int errors = 0;
   int tb_edges = 0;

   // Behavioural model
   logic [15:0] m_led;
   bit          m_ovr;
   logic [7:0]  m_rxq[$];
   logic [8:0]  tx_seen[$];   // {stop bit, data byte} per decoded frame

   lisp_io_registers #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .reset                (reset),
      .register_index       (register_index),
      .register_read        (register_read),
      .register_write       (register_write),
      .register_write_value (register_write_value),
      .register_read_value  (register_read_value),
      .uart_tx              (uart_tx),
      .uart_rx              (uart_rx),
      .led                  (led)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release: the value CYCLE must show
   always @(posedge clk) begin
      if (reset) tb_edges <= 0;
      else       tb_edges <= tb_edges + 1;
   end

   // Serial monitor: start detected at first low sample, bits at mid-period
   initial begin : tx_monitor
      logic [8:0] f;
      bit         ab;
      forever begin
         @(posedge clk); #1;
         if (reset === 1'b0 && uart_tx === 1'b0) begin
            f  = '0;
            ab = 0;
            for (int c = 1; c < 10 * CPB; c++) begin
               @(posedge clk); #1;
               if (reset !== 1'b0) ab = 1;
               if (c >= CPB + CPB/2 && c < 9 * CPB && ((c - CPB/2) % CPB) == 0)
                  f[(c - CPB/2) / CPB - 1] = uart_tx;
               if (c == 9 * CPB + CPB/2) f[8] = uart_tx;
            end
            if (!ab) tx_seen.push_back(f);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- helpers
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // One bus access; returns the registered read data one cycle later
   task automatic bus_cycle(input bit wr, input logic [6:0] idx,
                            input logic [15:0] val, output logic [15:0] rd);
      register_read        = 1'b1;
      register_write       = wr;
      register_index       = idx;
      register_write_value = val;
      @(posedge clk); #1;
      register_read  = 1'b0;
      register_write = 1'b0;
      rd = register_read_value;
   endtask

   function automatic logic [15:0] exp_status(input bit busy, input bit tx_nf);
      return {12'h000, busy, m_ovr, (m_rxq.size() != 0), tx_nf};
   endfunction

   task automatic send_rx(input logic [7:0] b, input bit stopb);
      uart_rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         idle(CPB);
      end
      uart_rx = stopb;
      idle(CPB);
      uart_rx = 1'b1;
      idle(stopb ? 4 : 2 * CPB);
      if (stopb) begin
         if (m_rxq.size() < DEPTH) m_rxq.push_back(b);
         else                      m_ovr = 1;
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      logic [15:0] rd;
      int e;
      idle(3);
      checks++;
      if (led !== 16'h0000) begin errors++; $display("FAIL reset_led: got %h expected 0000", led); end
      checks++;
      if (register_read_value !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", register_read_value); end
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
      reset = 1'b0;
      e = tb_edges;
      bus_cycle(0, A_CYCLE, 16'h0, rd);
      checks++;
      if (rd !== 16'(e)) begin errors++; $display("FAIL reset_cycle: got %h expected %h", rd, 16'(e)); end
      bus_cycle(0, A_STATUS, 16'h0, rd);
      checks++;
      if (rd !== exp_status(0, 1)) begin errors++; $display("FAIL reset_status: got %h expected %h", rd, exp_status(0, 1)); end
      idle(3);
      checks++;
      if (register_read_value !== exp_status(0, 1)) begin errors++; $display("FAIL read_hold: got %h expected %h", register_read_value, exp_status(0, 1)); end
   endtask

   task automatic test_led();
      logic [15:0] rd, v;
      logic [6:0]  idx;
      bus_cycle(1, A_LED, 16'hA5A5, rd);
      m_led = 16'hA5A5;
      checks++;
      if (led !== 16'hA5A5) begin errors++; $display("FAIL led_write: got %h expected a5a5", led); end
      bus_cycle(0, A_LED, 16'h0, rd);
      checks++;
      if (rd !== 16'hA5A5) begin errors++; $display("FAIL led_read: got %h expected a5a5", rd); end
      for (int n = 0; n < 3; n++) begin
         v = 16'($urandom);
         bus_cycle(1, A_LED, v, rd);
         m_led = v;
         bus_cycle(0, A_LED, 16'h0, rd);
         checks++;
         if (rd !== m_led || led !== m_led) begin errors++; $display("FAIL led_random: got %h/%h expected %h", rd, led, m_led); end
      end
      // Writes to read-only and unmapped indices are ignored
      for (int n = 0; n < 4; n++) begin
         idx = (n == 0) ? A_STATUS : (n == 1) ? A_CYCLE : 7'($urandom_range(5, 127));
         bus_cycle(1, idx, 16'($urandom), rd);
         checks++;
         if (led !== m_led) begin errors++; $display("FAIL led_ignore_wr idx %0d: got %h expected %h", idx, led, m_led); end
      end
      idx = 7'($urandom_range(5, 127));
      bus_cycle(0, idx, 16'h0, rd);
      checks++;
      if (rd !== 16'h0000) begin errors++; $display("FAIL unmapped_read idx %0d: got %h expected 0000", idx, rd); end
      bus_cycle(0, A_TX, 16'h0, rd);
      checks++;
      if (rd !== 16'h0000) begin errors++; $display("FAIL txdata_read: got %h expected 0000", rd); end
   endtask

   task automatic test_tx_pattern();
      logic [15:0] rd;
      logic [7:0]  b;
      logic        lv;
      bit          found;
      int          bad;
      b = 8'h55;
      tx_seen.delete();
      bus_cycle(1, A_TX, {8'h00, b}, rd);
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (uart_tx === 1'b0) found = 1;
         else idle(1);
      end
      checks++;
      if (!found) begin errors++; $display("FAIL tx_start: got no start bit expected start within 8 clks"); end
      for (int p = 0; p < 10; p++) begin
         lv  = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
         bad = 0;
         for (int c = 0; c < CPB; c++) begin
            if (uart_tx !== lv) bad++;
            idle(1);
         end
         checks++;
         if (bad != 0) begin errors++; $display("FAIL tx_bit_period %0d: got %0d wrong samples expected level %b for %0d clks", p, bad, lv, CPB); end
      end
      checks++;
      if (tx_seen.size() != 1 || tx_seen[0] !== {1'b1, b}) begin
         errors++; $display("FAIL tx_decode: got %0d frames expected one frame %h", tx_seen.size(), {1'b1, b});
      end
      tx_seen.delete();
   endtask

   task automatic test_tx_fifo();
      logic [15:0] rd;
      logic [7:0]  exp_q[$];
      logic [7:0]  v;
      tx_seen.delete();
      // Back-to-back writes; the first byte leaves for the shifter at once
      for (int n = 0; n < DEPTH + 1; n++) begin
         v = 8'($urandom);
         exp_q.push_back(v);
         register_read = 1'b1; register_write = 1'b1;
         register_index = A_TX; register_write_value = {8'($urandom), v};
         idle(1);
      end
      register_read = 1'b0; register_write = 1'b0;
      bus_cycle(0, A_STATUS, 16'h0, rd);
      checks++;
      if (rd !== exp_status(1, 0)) begin errors++; $display("FAIL tx_full_status: got %h expected %h", rd, exp_status(1, 0)); end
      bus_cycle(1, A_TX, 16'h00EE, rd);   // must be dropped
      for (int i = 0; i < 2000 && tx_seen.size() < DEPTH + 1; i++) idle(1);
      idle(12 * CPB);
      checks++;
      if (tx_seen.size() != DEPTH + 1) begin errors++; $display("FAIL tx_frame_count: got %0d expected %0d", tx_seen.size(), DEPTH + 1); end
      for (int i = 0; i < DEPTH + 1 && i < tx_seen.size(); i++) begin
         checks++;
         if (tx_seen[i] !== {1'b1, exp_q[i]}) begin errors++; $display("FAIL tx_frame %0d: got %h expected %h", i, tx_seen[i], {1'b1, exp_q[i]}); end
      end
      bus_cycle(0, A_STATUS, 16'h0, rd);
      checks++;
      if (rd !== exp_status(0, 1)) begin errors++; $display("FAIL tx_drained_status: got %h expected %h", rd, exp_status(0, 1)); end
      tx_seen.delete();
   endtask

   task automatic test_rx_basic();
      logic [15:0] rd, exp;
      send_rx(8'h3C, 1);
      bus_cycle(0, A_STATUS, 16'h0, rd);
      exp = exp_status(0, 1); m_ovr = 0;
      checks++;
      if (rd !== exp || rd[1] !== 1'b1) begin errors++; $display("FAIL rx_status_ready: got %h expected %h", rd, exp); end
      exp = (m_rxq.size() != 0) ? {8'h00, m_rxq.pop_front()} : 16'h0000;
      bus_cycle(0, A_RX, 16'h0, rd);
      checks++;
      if (rd !== exp || rd !== 16'h003C) begin errors++; $display("FAIL rx_data: got %h expected 003c", rd); end
      bus_cycle(0, A_STATUS, 16'h0, rd);
      checks++;
      if (rd !== exp_status(0, 1)) begin errors++; $display("FAIL rx_status_empty: got %h expected %h", rd, exp_status(0, 1)); end
   endtask

   task automatic test_rx_overrun();
      logic [15:0] rd, exp;
      for (int n = 0; n < DEPTH + 1; n++) send_rx(8'($urandom), 1);
      bus_cycle(0, A_STATUS, 16'h0, rd);
      exp = exp_status(0, 1); m_ovr = 0;
      checks++;
      if (rd !== exp || rd !== 16'h0007) begin errors++; $display("FAIL overrun_status: got %h expected %h", rd, exp); end
      bus_cycle(0, A_STATUS, 16'h0, rd);
      checks++;
      if (rd !== exp_status(0, 1)) begin errors++; $display("FAIL overrun_clear: got %h expected %h", rd, exp_status(0, 1)); end
      for (int n = 0; n < DEPTH + 1; n++) begin
         exp = (m_rxq.size() != 0) ? {8'h00, m_rxq.pop_front()} : 16'h0000;
         bus_cycle(0, A_RX, 16'h0, rd);
         checks++;
         if (rd !== exp) begin errors++; $display("FAIL overrun_data %0d: got %h expected %h", n, rd, exp); end
      end
      send_rx(8'($urandom), 0);   // framing error
      bus_cycle(0, A_STATUS, 16'h0, rd);
      checks++;
      if (rd !== exp_status(0, 1)) begin errors++; $display("FAIL framing_status: got %h expected %h", rd, exp_status(0, 1)); end
      send_rx(8'hC3, 1);
      exp = (m_rxq.size() != 0) ? {8'h00, m_rxq.pop_front()} : 16'h0000;
      bus_cycle(0, A_RX, 16'h0, rd);
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL rx_recover: got %h expected %h", rd, exp); end
   endtask

   task automatic test_random_access();
      logic [15:0] rd, exp, v;
      logic [6:0]  idx;
      int          e, r, sel;
      send_rx(8'($urandom), 1);
      send_rx(8'($urandom), 1);
      for (int n = 0; n < 24; n++) begin
         r = $urandom_range(0, 9);
         if (r < 3) begin
            sel = $urandom_range(0, 3);
            case (sel)
               0:       idx = A_LED;
               1:       idx = A_STATUS;
               2:       idx = A_RX;
               default: idx = 7'($urandom_range(5, 127));
            endcase
            v = 16'($urandom);
            bus_cycle(1, idx, v, rd);
            if (idx == A_LED) m_led = v;
            checks++;
            if (led !== m_led) begin errors++; $display("FAIL rand_write idx %0d: led got %h expected %h", idx, led, m_led); end
         end else begin
            idx = (r < 8) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(8, 127));
            e = tb_edges;
            case (idx)
               A_LED:    exp = m_led;
               A_STATUS: exp = exp_status(0, 1);
               A_RX:     exp = (m_rxq.size() != 0) ? {8'h00, m_rxq[0]} : 16'h0000;
               A_CYCLE:  exp = 16'(e);
               default:  exp = 16'h0000;
            endcase
            bus_cycle(0, idx, 16'($urandom), rd);
            if (idx == A_STATUS) m_ovr = 0;
            if (idx == A_RX && m_rxq.size() != 0) void'(m_rxq.pop_front());
            checks++;
            if (rd !== exp) begin errors++; $display("FAIL rand_read idx %0d: got %h expected %h", idx, rd, exp); end
         end
      end
   endtask

   task automatic test_reset_mid_tx();
      logic [15:0] rd;
      send_rx(8'h5A, 1);
      bus_cycle(1, A_LED, 16'h1234, rd);
      m_led = 16'h1234;
      tx_seen.delete();
      bus_cycle(1, A_TX, 16'h00F0, rd);
      idle(3 * CPB);
      reset = 1'b1;
      #1;
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_mid_uart_tx: got %b expected 1", uart_tx); end
      checks++;
      if (led !== 16'h0000 || register_read_value !== 16'h0000) begin
         errors++; $display("FAIL reset_mid_regs: got led %h rdata %h expected 0000 0000", led, register_read_value);
      end
      idle(2);
      reset = 1'b0;
      m_led = 16'h0000; m_ovr = 0; m_rxq.delete();
      bus_cycle(0, A_CYCLE, 16'h0, rd);
      checks++;
      if (rd !== 16'h0000) begin errors++; $display("FAIL reset_mid_cycle: got %h expected 0000", rd); end
      bus_cycle(0, A_STATUS, 16'h0, rd);
      checks++;
      if (rd !== 16'h0001) begin errors++; $display("FAIL reset_mid_status: got %h expected 0001", rd); end
      idle(12 * CPB);
      checks++;
      if (tx_seen.size() != 0) begin errors++; $display("FAIL reset_mid_no_frame: got %0d frames expected 0", tx_seen.size()); end
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      reset                = 1'b1;
      uart_rx              = 1'b1;
      register_index       = '0;
      register_read        = 1'b0;
      register_write       = 1'b0;
      register_write_value = '0;
      m_led                = '0;
      m_ovr                = 0;

      test_reset();
      test_led();
      test_tx_pattern();
      test_tx_fifo();
      test_rx_basic();
      test_rx_overrun();
      test_random_access();
      test_reset_mid_tx();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
